// File: rtl/fall_event_fsm.sv
// Fall detector fed by a magnitude stream: recognises free-fall, then impact, then rest,
// and reports a confirmed fall as a one-cycle pulse plus a sticky flag.
module fall_event_fsm #(
    parameter logic [15:0] FF_THRESH      = 16'd64,
    parameter logic [15:0] IMPACT_THRESH  = 16'd640,
    parameter logic [15:0] REST_LOW       = 16'd200,
    parameter logic [15:0] REST_HIGH      = 16'd320,
    parameter int unsigned FF_MIN_SAMPLES = 4,
    parameter int unsigned IMPACT_WINDOW  = 8,
    parameter int unsigned REST_SAMPLES   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mag_valid,
    input  logic [15:0] magnitude,
    input  logic        clear,
    output logic        fall_pulse,
    output logic        fall_flag,
    output logic [15:0] peak_mag,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FREEFALL    = 3'd1,
        IMPACT_WAIT = 3'd2,
        REST_CHECK  = 3'd3,
        FALL        = 3'd4
    } state_t;

    localparam logic [7:0] FF_MIN  = 8'(FF_MIN_SAMPLES);
    localparam logic [7:0] WINDOW  = 8'(IMPACT_WINDOW);
    localparam logic [7:0] REST_N  = 8'(REST_SAMPLES);

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic       is_ff;
    logic       is_impact;
    logic       in_band;

    // Counter saturates so a very long free-fall never wraps back below the minimum.
    assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign is_ff     = magnitude < FF_THRESH;
    assign is_impact = magnitude >= IMPACT_THRESH;
    assign in_band   = (magnitude >= REST_LOW) && (magnitude <= REST_HIGH);
    assign state_out = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            fall_pulse <= 1'b0;
            fall_flag  <= 1'b0;
            peak_mag   <= 16'd0;
        end else begin
            fall_pulse <= 1'b0;
            if (clear) begin
                // Acknowledge wins over any sample arriving in the same cycle.
                state     <= IDLE;
                cnt       <= 8'd0;
                fall_flag <= 1'b0;
            end else if (mag_valid) begin
                case (state)
                    IDLE: begin
                        if (is_ff) begin
                            state <= FREEFALL;
                            cnt   <= 8'd1;
                        end
                    end
                    FREEFALL: begin
                        if (is_ff) begin
                            cnt <= cnt_inc;
                        end else if (cnt < FF_MIN) begin
                            state <= IDLE;
                            cnt   <= 8'd0;
                        end else if (is_impact) begin
                            // The sample ending free-fall is itself the first window sample.
                            state    <= REST_CHECK;
                            cnt      <= 8'd0;
                            peak_mag <= magnitude;
                        end else if (WINDOW <= 8'd1) begin
                            state <= IDLE;
                            cnt   <= 8'd0;
                        end else begin
                            state <= IMPACT_WAIT;
                            cnt   <= 8'd1;
                        end
                    end
                    IMPACT_WAIT: begin
                        if (is_impact) begin
                            state    <= REST_CHECK;
                            cnt      <= 8'd0;
                            peak_mag <= magnitude;
                        end else if (cnt_inc >= WINDOW) begin
                            state <= IDLE;
                            cnt   <= 8'd0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    REST_CHECK: begin
                        if (!in_band) begin
                            state <= IDLE;
                            cnt   <= 8'd0;
                        end else if (cnt_inc >= REST_N) begin
                            state      <= FALL;
                            cnt        <= cnt_inc;
                            fall_pulse <= 1'b1;
                            fall_flag  <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    FALL: begin
                        fall_flag <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fall_event_fsm.sv
// Directed-vector bench for fall_event_fsm; each scenario task checks its own results.
module tb_fall_event_fsm;

    logic        clk;
    logic        reset_n;
    logic        mag_valid;
    logic [15:0] magnitude;
    logic        clear;
    logic        fall_pulse;
    logic        fall_flag;
    logic [15:0] peak_mag;
    logic [2:0]  state_out;

    int checks;
    int errors;
    int pulse_cnt;

    fall_event_fsm dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mag_valid (mag_valid),
        .magnitude (magnitude),
        .clear     (clear),
        .fall_pulse(fall_pulse),
        .fall_flag (fall_flag),
        .peak_mag  (peak_mag),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (fall_pulse === 1'b1) pulse_cnt++;

    // Present one sample for one edge; outputs are observed 1 time unit after that edge.
    task automatic send(input logic [15:0] m);
        mag_valid = 1'b1;
        magnitude = m;
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) send(m);
    endtask

    task automatic idle(input int n);
        mag_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        mag_valid = 1'b0;
        clear     = 1'b0;
        magnitude = 16'd0;
        reset_n   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (state_out !== 3'd0 || fall_pulse !== 1'b0 || fall_flag !== 1'b0 || peak_mag !== 16'd0) begin
            errors++;
            $display("FAIL reset: state=%0d pulse=%b flag=%b peak=%0d, required 0/0/0/0",
                     state_out, fall_pulse, fall_flag, peak_mag);
        end
        $display("test_reset done");
    endtask

    task automatic test_nominal();
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        send_n(16'd20, 5);
        send(16'd700);
        checks++;
        if (state_out !== 3'd3 || peak_mag !== 16'd700) begin
            errors++;
            $display("FAIL nominal_impact: state=%0d peak=%0d, required 3/700", state_out, peak_mag);
        end
        send_n(16'd256, 15);
        checks++;
        if (state_out !== 3'd3 || fall_pulse !== 1'b0 || pulse_cnt != p0) begin
            errors++;
            $display("FAIL nominal_early: state=%0d pulse=%b, required 3/0", state_out, fall_pulse);
        end
        send(16'd256);
        checks++;
        if (fall_pulse !== 1'b1 || fall_flag !== 1'b1 || state_out !== 3'd4 || peak_mag !== 16'd700) begin
            errors++;
            $display("FAIL nominal_fall: pulse=%b flag=%b state=%0d peak=%0d, required 1/1/4/700",
                     fall_pulse, fall_flag, state_out, peak_mag);
        end
        idle(2);
        checks++;
        if (fall_pulse !== 1'b0 || fall_flag !== 1'b1 || pulse_cnt - p0 != 1) begin
            errors++;
            $display("FAIL nominal_pulse_width: pulse=%b flag=%b pulses=%0d, required 0/1/1",
                     fall_pulse, fall_flag, pulse_cnt - p0);
        end
        $display("test_nominal done");
    endtask

    // Runs straight after test_nominal, while the FSM sits in FALL.
    task automatic test_clear_priority();
        send_n(16'd20, 3);
        send(16'd700);
        checks++;
        if (state_out !== 3'd4 || fall_flag !== 1'b1 || fall_pulse !== 1'b0 || peak_mag !== 16'd700) begin
            errors++;
            $display("FAIL fall_ignores: state=%0d flag=%b pulse=%b peak=%0d, required 4/1/0/700",
                     state_out, fall_flag, fall_pulse, peak_mag);
        end
        clear = 1'b1;
        send(16'd20);
        clear = 1'b0;
        mag_valid = 1'b0;
        checks++;
        if (state_out !== 3'd0 || fall_flag !== 1'b0 || peak_mag !== 16'd700) begin
            errors++;
            $display("FAIL clear_priority: state=%0d flag=%b peak=%0d, required 0/0/700",
                     state_out, fall_flag, peak_mag);
        end
        $display("test_clear_priority done");
    endtask

    task automatic test_short_freefall();
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        send_n(16'd20, 3);
        send(16'd700);
        checks++;
        if (state_out !== 3'd0 || peak_mag !== 16'd0) begin
            errors++;
            $display("FAIL short_ff: state=%0d peak=%0d, required 0/0", state_out, peak_mag);
        end
        send_n(16'd256, 16);
        idle(1);
        checks++;
        if (state_out !== 3'd0 || pulse_cnt != p0 || fall_flag !== 1'b0 || peak_mag !== 16'd0) begin
            errors++;
            $display("FAIL short_ff_nopulse: state=%0d pulses=%0d flag=%b peak=%0d, required 0/0/0/0",
                     state_out, pulse_cnt - p0, fall_flag, peak_mag);
        end
        $display("test_short_freefall done");
    endtask

    task automatic test_window_expiry();
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        send_n(16'd20, 4);
        send(16'd300);
        checks++;
        if (state_out !== 3'd2) begin
            errors++;
            $display("FAIL window_enter: state=%0d, required 2", state_out);
        end
        send_n(16'd300, 6);
        checks++;
        if (state_out !== 3'd2) begin
            errors++;
            $display("FAIL window_7th: state=%0d, required 2", state_out);
        end
        send(16'd300);
        idle(1);
        checks++;
        if (state_out !== 3'd0 || pulse_cnt != p0) begin
            errors++;
            $display("FAIL window_expire: state=%0d pulses=%0d, required 0/0", state_out, pulse_cnt - p0);
        end
        $display("test_window_expiry done");
    endtask

    task automatic test_rest_broken();
        apply_reset();
        send_n(16'd20, 4);
        send(16'd800);
        send_n(16'd256, 10);
        checks++;
        if (state_out !== 3'd3 || peak_mag !== 16'd800) begin
            errors++;
            $display("FAIL rest_progress: state=%0d peak=%0d, required 3/800", state_out, peak_mag);
        end
        send(16'd400);
        idle(1);
        checks++;
        if (state_out !== 3'd0 || fall_flag !== 1'b0 || peak_mag !== 16'd800) begin
            errors++;
            $display("FAIL rest_broken: state=%0d flag=%b peak=%0d, required 0/0/800",
                     state_out, fall_flag, peak_mag);
        end
        $display("test_rest_broken done");
    endtask

    task automatic test_thresholds();
        apply_reset();
        send_n(16'd64, 5);
        checks++;
        if (state_out !== 3'd0) begin
            errors++;
            $display("FAIL ff_thresh_64: state=%0d, required 0", state_out);
        end
        send_n(16'd63, 4);
        send(16'd639);
        checks++;
        if (state_out !== 3'd2) begin
            errors++;
            $display("FAIL impact_639: state=%0d, required 2", state_out);
        end
        send(16'd640);
        checks++;
        if (state_out !== 3'd3 || peak_mag !== 16'd640) begin
            errors++;
            $display("FAIL impact_640: state=%0d peak=%0d, required 3/640", state_out, peak_mag);
        end
        send(16'd200);
        send(16'd320);
        checks++;
        if (state_out !== 3'd3) begin
            errors++;
            $display("FAIL band_edges: state=%0d, required 3", state_out);
        end
        send(16'd199);
        idle(1);
        checks++;
        if (state_out !== 3'd0) begin
            errors++;
            $display("FAIL band_199: state=%0d, required 0", state_out);
        end
        send_n(16'd0, 4);
        send(16'd700);
        send(16'd321);
        idle(1);
        checks++;
        if (state_out !== 3'd0 || peak_mag !== 16'd700) begin
            errors++;
            $display("FAIL band_321: state=%0d peak=%0d, required 0/700", state_out, peak_mag);
        end
        $display("test_thresholds done");
    endtask

    task automatic test_saturation();
        apply_reset();
        send_n(16'd10, 300);
        send(16'd1000);
        idle(1);
        checks++;
        if (state_out !== 3'd3 || peak_mag !== 16'd1000) begin
            errors++;
            $display("FAIL cnt_saturate: state=%0d peak=%0d, required 3/1000", state_out, peak_mag);
        end
        $display("test_saturation done");
    endtask

    task automatic test_gaps();
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        send(16'd20);
        idle(3);
        checks++;
        if (state_out !== 3'd1) begin
            errors++;
            $display("FAIL gap_ff_hold: state=%0d, required 1", state_out);
        end
        for (int i = 0; i < 3; i++) begin
            send(16'd20);
            idle(2);
        end
        send(16'd700);
        idle(2);
        checks++;
        if (state_out !== 3'd3 || peak_mag !== 16'd700) begin
            errors++;
            $display("FAIL gap_impact: state=%0d peak=%0d, required 3/700", state_out, peak_mag);
        end
        for (int i = 0; i < 15; i++) begin
            send(16'd256);
            idle(1);
        end
        checks++;
        if (state_out !== 3'd3 || pulse_cnt != p0) begin
            errors++;
            $display("FAIL gap_rest_15: state=%0d pulses=%0d, required 3/0", state_out, pulse_cnt - p0);
        end
        send(16'd256);
        checks++;
        if (fall_pulse !== 1'b1 || state_out !== 3'd4 || fall_flag !== 1'b1) begin
            errors++;
            $display("FAIL gap_fall: pulse=%b state=%0d flag=%b, required 1/4/1", fall_pulse, state_out, fall_flag);
        end
        idle(1);
        $display("test_gaps done");
    endtask

    task automatic test_async_reset();
        apply_reset();
        send_n(16'd20, 4);
        send(16'd700);
        send_n(16'd256, 5);
        mag_valid = 1'b0;
        checks++;
        if (state_out !== 3'd3) begin
            errors++;
            $display("FAIL areset_setup: state=%0d, required 3", state_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (state_out !== 3'd0 || fall_pulse !== 1'b0 || fall_flag !== 1'b0 || peak_mag !== 16'd0) begin
            errors++;
            $display("FAIL areset_immediate: state=%0d pulse=%b flag=%b peak=%0d, required 0/0/0/0",
                     state_out, fall_pulse, fall_flag, peak_mag);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_n(16'd256, 16);
        idle(1);
        checks++;
        if (state_out !== 3'd0 || fall_flag !== 1'b0) begin
            errors++;
            $display("FAIL areset_aborted: state=%0d flag=%b, required 0/0", state_out, fall_flag);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        pulse_cnt = 0;
        reset_n   = 1'b0;
        mag_valid = 1'b0;
        magnitude = 16'd0;
        clear     = 1'b0;
        test_reset();
        test_nominal();
        test_clear_priority();
        test_short_freefall();
        test_window_expiry();
        test_rest_broken();
        test_thresholds();
        test_saturation();
        test_gaps();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
